// File: rtl/dmem_arbiter_if.sv
// ============================================================================
//  Module   : dmem_arbiter_if
//  Purpose  : Bundles the two requester ports and the data-memory port of the
//             dmem_arbiter so they travel as one connection.
//  Ports    : req/we/lock/addr/wdata per requester (0 = core LSU, 1 = debug/DMA),
//             gnt/rvalid/rdata back to each requester, and the single-port
//             memory strobe/address/data plus mem_read_data from memory.
//  Modports : slave  - arbiter view
//             master - requester/memory view (testbench or surrounding logic)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
  parameter int AW = 5
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic          lock0;
  logic          lock1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [31:0]   wdata0;
  logic [31:0]   wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [31:0]   rdata0;
  logic [31:0]   rdata1;
  logic          mem_wr_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1,
    input  addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_wr_rd_en, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1,
    output addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_wr_rd_en, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-port arbiter in front of a single-port data memory. One
//             access per cycle, round-robin on contention, optional lock for
//             read-modify-write sequences, 1-deep read-return tracking.
//  Ports    : clk  - clock, all state on rising edge
//             rst  - synchronous, active-low reset
//             bus  - dmem_arbiter_if.slave (requesters + memory port)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int AW = 5
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rr;        // 0: port 0 wins next tie, 1: port 1 wins
  logic          r_tag_vld;   // a read was granted last cycle
  logic          r_tag_port;  // which port that read belongs to
  logic          w_gnt0;
  logic          w_gnt1;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_wdata;
  logic          w_mem_we;
  logic          w_rvalid0;
  logic          w_rvalid1;

  // Grant and next-state decision. Everything is held off while rst is low so
  // the outputs are quiet during reset regardless of requests.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    if (rst) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req0 && bus.req1) begin
            if (r_rr) w_gnt1 = 1'b1;
            else      w_gnt0 = 1'b1;
          end else begin
            w_gnt0 = bus.req0;
            w_gnt1 = bus.req1;
          end
          if (w_gnt0 && bus.lock0)      w_state_nxt = ST_OWN0;
          else if (w_gnt1 && bus.lock1) w_state_nxt = ST_OWN1;
        end
        ST_OWN0: begin
          // The other port is locked out for as long as the owner keeps lock.
          w_gnt0 = bus.req0;
          if (!bus.req0 || !bus.lock0) w_state_nxt = ST_IDLE;
        end
        ST_OWN1: begin
          w_gnt1 = bus.req1;
          if (!bus.req1 || !bus.lock1) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Memory port mux; idle cycles present a zero-address dummy read, which the
  // tag below never turns into an rvalid.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = 32'd0;
    if (w_gnt0) begin
      w_mem_we    = bus.we0;
      w_mem_addr  = bus.addr0;
      w_mem_wdata = bus.wdata0;
    end else if (w_gnt1) begin
      w_mem_we    = bus.we1;
      w_mem_addr  = bus.addr1;
      w_mem_wdata = bus.wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rr       <= 1'b0;
      r_tag_vld  <= 1'b0;
      r_tag_port <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt0)      r_rr <= 1'b1;
      else if (w_gnt1) r_rr <= 1'b0;
      r_tag_vld  <= (w_gnt0 && !bus.we0) || (w_gnt1 && !bus.we1);
      r_tag_port <= w_gnt1;
    end
  end

  // rst gating hides a tag captured just before reset was asserted.
  assign w_rvalid0 = rst && r_tag_vld && !r_tag_port;
  assign w_rvalid1 = rst && r_tag_vld &&  r_tag_port;

  assign bus.gnt0           = w_gnt0;
  assign bus.gnt1           = w_gnt1;
  assign bus.mem_wr_rd_en   = w_mem_we;
  assign bus.mem_addr       = w_mem_addr;
  assign bus.mem_write_data = w_mem_wdata;
  assign bus.rvalid0        = w_rvalid0;
  assign bus.rvalid1        = w_rvalid1;
  assign bus.rdata0         = w_rvalid0 ? bus.mem_read_data : 32'd0;
  assign bus.rdata1         = w_rvalid1 ? bus.mem_read_data : 32'd0;

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one parameter: AW, default 5, data-memory word-address width.
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req0, req1  input  1 each  access request; port 0 = core load/store unit, port 1 = debug/DMA.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 lock0, lock1  input  1 each  hold ownership after this access (read-modify-write).
REQ-007 addr0, addr1  input  AW each  word address.
REQ-008 wdata0, wdata1  input  32 each  write data.
REQ-009 gnt0, gnt1  output  1 each  access accepted this cycle (combinational).
REQ-010 rvalid0, rvalid1  output  1 each  read data valid (registered).
REQ-011 rdata0, rdata1  output  32 each  read data.
REQ-012 mem_wr_rd_en  output  1  memory strobe; 1 = write, 0 = read.
REQ-013 mem_addr  output  AW  memory address.
REQ-014 mem_write_data  output  32  memory write data.
REQ-015 mem_read_data  input  32  memory read data; valid one cycle after its read address is presented.

Function
REQ-016 One access per cycle; gnt0 and gnt1 SHALL never be high together.
REQ-017 FSM states: IDLE, OWN0, OWN1.
REQ-018 IDLE, one request: grant that port.
REQ-019 IDLE, both requesting: grant the port not granted last (round-robin pointer rr).
REQ-020 rr after reset SHALL favour port 0; rr SHALL update on every grant.
REQ-021 Granted port with lockN=1: next state OWNN. Otherwise the FSM stays in IDLE.
REQ-022 OWNN: only port N is grantable; the other port's req SHALL be ignored, gnt held low.
REQ-023 OWNN: return to IDLE on the first cycle where reqN=0, or where port N is granted with lockN=0.
REQ-024 The lock SHALL NOT time out.
REQ-025 Granted cycle: mem_addr = addrN, mem_write_data = wdataN, mem_wr_rd_en = weN.
REQ-026 No grant: mem_wr_rd_en = 0, mem_addr = 0, mem_write_data = 0. The resulting dummy read SHALL NOT produce rvalid.
REQ-027 Write: complete at the granting clock edge; no rvalid.
REQ-028 Read granted in cycle T: rvalidN = 1 in cycle T+1 only, with rdataN = mem_read_data.
REQ-029 Tracking is a 1-deep registered tag (valid, port id).
REQ-030 Back-to-back grants every cycle SHALL be supported, including read after write to the same address, which SHALL return the new data.
REQ-031 rdataN SHALL be 0 whenever rvalidN = 0.
REQ-032 req with no gnt: the requester holds req/we/addr/wdata stable; the arbiter SHALL NOT buffer requests.

Reset
REQ-033 rst=0 at posedge: state=IDLE, rr->port 0, read tag cleared.
REQ-034 During reset: gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0, mem_wr_rd_en = 0, mem_addr = 0, mem_write_data = 0, regardless of req.
REQ-035 Reset asserted while in OWNN or with a read outstanding: lock and pending rvalid SHALL be discarded; no rvalid after reset release.
REQ-036 First cycle after reset release: arbitrate normally from IDLE.

Verification
REQ-037 req0 alone, we0=1, addr0=3, wdata0=0x12345678; next cycle req0 read addr 3 -> gnt0 both cycles; rvalid0=1 one cycle after the read grant, rdata0=0x12345678.
REQ-038 req0 and req1 both held as reads for 4 cycles after reset -> grants alternate 0,1,0,1; each rvalid matches its port one cycle later.
REQ-039 Port 1: lock1=1 read addr 7, then lock1=0 write addr 7 = 0xA5A5A5A5, req0 asserted throughout -> gnt0 low both cycles; gnt0 high the following cycle.
REQ-040 Port 0: lock0=1 grant, then req0 dropped -> FSM returns to IDLE; req1 granted next cycle.
REQ-041 rst=0 in cycle after a read grant in OWN0 -> rvalid0 stays 0; after release, req1 alone is granted immediately.
REQ-042 No requests for 3 cycles -> mem_wr_rd_en=0, mem_addr=0, rvalid0/1=0 throughout.
